// File: rtl/rom_arbitro.sv
// -----------------------------------------------------------------------------
// rom_arbitro
//
// Two-requester round-robin arbiter and read sequencer in front of a shared
// combinational ROM with a single read port. The block owns the ROM address
// bus, grants one requester at a time and hands back registered read data
// with a one-cycle valid strobe to the requester that won.
//
// Transaction timeline (request sampled at edge N):
//   cycle N+1 : LECTURA  - gnt<winner> high, dir_rom holds winner's address
//   cycle N+2 : ENTREGA  - valid<winner> high, dato_o/err_o hold the result
//   edge  N+3 : earliest next arbitration (one read every three cycles)
//
// Parameters:
//   ANCHO_DIR   - address width of requesters and ROM address bus
//   ANCHO_DATO  - data width of ROM and returned data
//   PROFUNDIDAD - number of valid ROM entries (legal addresses 0..PROFUNDIDAD-1)
//
// Ports:
//   clk               system clock, all state updates on rising edge
//   rst               synchronous active-high reset
//   req0/dir0         request and address from requester 0
//   gnt0/valid0       grant pulse and data strobe to requester 0
//   req1/dir1         request and address from requester 1
//   gnt1/valid1       grant pulse and data strobe to requester 1
//   dato_o            registered read data, shared by both requesters
//   err_o             out-of-range flag, meaningful only with valid0/valid1
//   ocupado           high whenever a transaction is in flight
//   dir_rom           registered address driven to the ROM
//   dato_rom          combinational data returned by the ROM
//
// Build option:
//   ROM_RANGO_CHECK_EN - when defined, addresses >= PROFUNDIDAD return zero
//                        data with err_o set; when undefined err_o is tied 0
//                        and ROM data is passed through unconditionally.
// -----------------------------------------------------------------------------
module rom_arbitro #(
  parameter int ANCHO_DIR   = 8,
  parameter int ANCHO_DATO  = 8,
  parameter int PROFUNDIDAD = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic [ANCHO_DIR-1:0]  dir0,
  output logic                  gnt0,
  output logic                  valid0,
  input  logic                  req1,
  input  logic [ANCHO_DIR-1:0]  dir1,
  output logic                  gnt1,
  output logic                  valid1,
  output logic [ANCHO_DATO-1:0] dato_o,
  output logic                  err_o,
  output logic                  ocupado,
  output logic [ANCHO_DIR-1:0]  dir_rom,
  input  logic [ANCHO_DATO-1:0] dato_rom
);

  typedef enum logic [1:0] {
    LIBRE   = 2'd0,
    LECTURA = 2'd1,
    ENTREGA = 2'd2
  } estado_t;

  estado_t estado, estado_sig;

  // ganador: requester owning the current transaction (0 or 1).
  // puntero: requester favoured when both request in the same cycle.
  logic ganador, ganador_sig;
  logic puntero, puntero_sig;

  logic [ANCHO_DIR-1:0]  dir_sig;
  logic [ANCHO_DATO-1:0] dato_sig;
  logic                  gnt0_sig, gnt1_sig;
  logic                  valid0_sig, valid1_sig;
  logic                  ocupado_sig;
  logic                  fuera_rango;

  assign fuera_rango = (dir_rom >= ANCHO_DIR'(PROFUNDIDAD));

`ifdef ROM_RANGO_CHECK_EN
  logic err_sig;
`else
  // The range comparison is only consulted when the check is compiled in.
  logic unused_fuera_rango;
  assign unused_fuera_rango = fuera_rango;
  assign err_o              = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    estado_sig  = estado;
    ganador_sig = ganador;
    puntero_sig = puntero;
    dir_sig     = dir_rom;
    dato_sig    = dato_o;
`ifdef ROM_RANGO_CHECK_EN
    err_sig     = err_o;
`endif

    case (estado)
      LIBRE: begin
        if (req0 || req1) begin
          // NOTE: blocking assignments in combinational logic let the winner
          // chosen on the line below feed the address mux in the same pass.
          if (req0 && req1) ganador_sig = puntero;
          else              ganador_sig = req1;
          dir_sig    = ganador_sig ? dir1 : dir0;
          estado_sig = LECTURA;
        end
      end

      LECTURA: begin
        // dir_rom was registered on the previous edge, so dato_rom is settled.
`ifdef ROM_RANGO_CHECK_EN
        if (fuera_rango) begin
          dato_sig = '0;
          err_sig  = 1'b1;
        end else begin
          dato_sig = dato_rom;
          err_sig  = 1'b0;
        end
`else
        dato_sig = dato_rom;
`endif
        estado_sig = ENTREGA;
      end

      ENTREGA: begin
        // Hand priority to the requester that just lost (or did not ask).
        puntero_sig = ~ganador;
        estado_sig  = LIBRE;
      end

      default: begin
        estado_sig = LIBRE;
      end
    endcase

    // Outputs are decoded from the next state and registered below, so they
    // line up with the state they describe and never glitch.
    gnt0_sig    = (estado_sig == LECTURA) && !ganador_sig;
    gnt1_sig    = (estado_sig == LECTURA) &&  ganador_sig;
    valid0_sig  = (estado_sig == ENTREGA) && !ganador_sig;
    valid1_sig  = (estado_sig == ENTREGA) &&  ganador_sig;
    ocupado_sig = (estado_sig != LIBRE);
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all registered state, so every
    // register samples pre-edge values regardless of statement order.
    if (rst) begin
      // A reset in the middle of a transaction simply drops it; the
      // requester still holds req and is re-arbitrated from LIBRE.
      estado  <= LIBRE;
      ganador <= 1'b0;
      puntero <= 1'b0;
      dir_rom <= '0;
      dato_o  <= '0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      valid0  <= 1'b0;
      valid1  <= 1'b0;
      ocupado <= 1'b0;
`ifdef ROM_RANGO_CHECK_EN
      err_o   <= 1'b0;
`endif
    end else begin
      estado  <= estado_sig;
      ganador <= ganador_sig;
      puntero <= puntero_sig;
      dir_rom <= dir_sig;
      dato_o  <= dato_sig;
      gnt0    <= gnt0_sig;
      gnt1    <= gnt1_sig;
      valid0  <= valid0_sig;
      valid1  <= valid1_sig;
      ocupado <= ocupado_sig;
`ifdef ROM_RANGO_CHECK_EN
      err_o   <= err_sig;
`endif
    end
  end

endmodule

// File: tb/tb_rom_arbitro.sv
// -----------------------------------------------------------------------------
// tb_rom_arbitro
//
// Directed self-checking bench for rom_arbitro. A small combinational ROM
// model answers dir_rom. Inputs are driven and outputs sampled 1 time unit
// after each rising edge. Status bits are compared as the packed vector
// {gnt0, gnt1, valid0, valid1, ocupado}.
// -----------------------------------------------------------------------------
module tb_rom_arbitro;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [7:0] dir0, dir1;
  logic       gnt0, gnt1, valid0, valid1;
  logic [7:0] dato_o;
  logic       err_o;
  logic       ocupado;
  logic [7:0] dir_rom;
  logic [7:0] dato_rom;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rom_arbitro #(
    .ANCHO_DIR  (8),
    .ANCHO_DATO (8),
    .PROFUNDIDAD(11)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req0     (req0),
    .dir0     (dir0),
    .gnt0     (gnt0),
    .valid0   (valid0),
    .req1     (req1),
    .dir1     (dir1),
    .gnt1     (gnt1),
    .valid1   (valid1),
    .dato_o   (dato_o),
    .err_o    (err_o),
    .ocupado  (ocupado),
    .dir_rom  (dir_rom),
    .dato_rom (dato_rom)
  );

  // ROM contents: 90,80,...,10 at 0..8, then 100 and 101. Beyond range the
  // model returns 0xEE so a missing range check would be visible.
  always_comb begin
    case (dir_rom)
      8'd0:    dato_rom = 8'd90;
      8'd1:    dato_rom = 8'd80;
      8'd2:    dato_rom = 8'd70;
      8'd3:    dato_rom = 8'd60;
      8'd4:    dato_rom = 8'd50;
      8'd5:    dato_rom = 8'd40;
      8'd6:    dato_rom = 8'd30;
      8'd7:    dato_rom = 8'd20;
      8'd8:    dato_rom = 8'd10;
      8'd9:    dato_rom = 8'd100;
      8'd10:   dato_rom = 8'd101;
      default: dato_rom = 8'hEE;
    endcase
  end

  // Grants and strobes must be mutually exclusive on every cycle.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      checks++;
      if ((gnt0 && gnt1) || (valid0 && valid1)) begin
        errors++;
        $display("FAIL exclusive: gnt=%b%b valid=%b%b, required no pair high",
                 gnt0, gnt1, valid0, valid1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; dir0 = '0; dir1 = '0;
    tick(); tick();
    rst = 1'b0;
    repeat (5) tick();
    checks++;
    if ({gnt0, gnt1, valid0, valid1, ocupado} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_status: got %b, required 00000",
               {gnt0, gnt1, valid0, valid1, ocupado});
    end
    checks++;
    if ({dato_o, err_o, dir_rom} !== 17'd0) begin
      errors++;
      $display("FAIL reset_data: dato_o=%0d err_o=%b dir_rom=%0d, required 0 0 0",
               dato_o, err_o, dir_rom);
    end
  endtask

  task automatic test_single_req0();
    req0 = 1'b1; dir0 = 8'd3;
    tick();
    checks++;
    if ({gnt0, gnt1, valid0, valid1, ocupado} !== 5'b10001 || dir_rom !== 8'd3) begin
      errors++;
      $display("FAIL single_gnt: status=%b dir_rom=%0d, required 10001 3",
               {gnt0, gnt1, valid0, valid1, ocupado}, dir_rom);
    end
    req0 = 1'b0;
    tick();
    checks++;
    if ({gnt0, gnt1, valid0, valid1, ocupado} !== 5'b00101 ||
        dato_o !== 8'd60 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL single_valid: status=%b dato_o=%0d err_o=%b, required 00101 60 0",
               {gnt0, gnt1, valid0, valid1, ocupado}, dato_o, err_o);
    end
    tick();
    checks++;
    if ({gnt0, gnt1, valid0, valid1, ocupado} !== 5'b00000 ||
        dato_o !== 8'd60 || dir_rom !== 8'd3) begin
      errors++;
      $display("FAIL single_hold: status=%b dato_o=%0d dir_rom=%0d, required 00000 60 3",
               {gnt0, gnt1, valid0, valid1, ocupado}, dato_o, dir_rom);
    end
  endtask

  // Both requesters high straight out of reset: pointer favours 0.
  task automatic test_both_from_reset();
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1; dir0 = 8'd0; dir1 = 8'd9;
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({gnt0, gnt1} !== 2'b10 || dir_rom !== 8'd0) begin
      errors++;
      $display("FAIL both_first_gnt: gnt=%b dir_rom=%0d, required 10 0",
               {gnt0, gnt1}, dir_rom);
    end
    req0 = 1'b0;
    tick();
    checks++;
    if ({valid0, valid1} !== 2'b10 || dato_o !== 8'd90) begin
      errors++;
      $display("FAIL both_first_valid: valid=%b dato_o=%0d, required 10 90",
               {valid0, valid1}, dato_o);
    end
    tick();
    tick();
    checks++;
    if ({gnt0, gnt1} !== 2'b01 || dir_rom !== 8'd9) begin
      errors++;
      $display("FAIL both_second_gnt: gnt=%b dir_rom=%0d, required 01 9",
               {gnt0, gnt1}, dir_rom);
    end
    req1 = 1'b0;
    tick();
    checks++;
    if ({valid0, valid1} !== 2'b01 || dato_o !== 8'd100) begin
      errors++;
      $display("FAIL both_second_valid: valid=%b dato_o=%0d, required 01 100",
               {valid0, valid1}, dato_o);
    end
    tick();
  endtask

  // Both requests held: winners alternate 0,1,0,1 with one read per 3 cycles.
  task automatic test_back_to_back();
    logic [4:0] exp_gnt, exp_val;
    logic [7:0] exp_dato;
    req0 = 1'b1; req1 = 1'b1; dir0 = 8'd10; dir1 = 8'd8;
    for (int t = 0; t < 4; t++) begin
      exp_gnt  = (t % 2 == 0) ? 5'b10001 : 5'b01001;
      exp_val  = (t % 2 == 0) ? 5'b00101 : 5'b00011;
      exp_dato = (t % 2 == 0) ? 8'd101   : 8'd10;
      tick();
      checks++;
      if ({gnt0, gnt1, valid0, valid1, ocupado} !== exp_gnt) begin
        errors++;
        $display("FAIL b2b_gnt[%0d]: got %b, required %b",
                 t, {gnt0, gnt1, valid0, valid1, ocupado}, exp_gnt);
      end
      tick();
      checks++;
      if ({gnt0, gnt1, valid0, valid1, ocupado} !== exp_val || dato_o !== exp_dato) begin
        errors++;
        $display("FAIL b2b_valid[%0d]: status=%b dato_o=%0d, required %b %0d",
                 t, {gnt0, gnt1, valid0, valid1, ocupado}, dato_o, exp_val, exp_dato);
      end
      if (t == 3) begin
        req0 = 1'b0; req1 = 1'b0;
      end
      tick();
      checks++;
      if (ocupado !== 1'b0) begin
        errors++;
        $display("FAIL b2b_idle[%0d]: ocupado=%b, required 0", t, ocupado);
      end
    end
  endtask

  task automatic test_range();
    req1 = 1'b1; dir1 = 8'd11;
    tick();
    checks++;
    if ({gnt0, gnt1} !== 2'b01 || dir_rom !== 8'd11) begin
      errors++;
      $display("FAIL range_gnt: gnt=%b dir_rom=%0d, required 01 11", {gnt0, gnt1}, dir_rom);
    end
    req1 = 1'b0;
    tick();
`ifdef ROM_RANGO_CHECK_EN
    checks++;
    if (valid1 !== 1'b1 || dato_o !== 8'd0 || err_o !== 1'b1) begin
      errors++;
      $display("FAIL range_oob: valid1=%b dato_o=%0d err_o=%b, required 1 0 1",
               valid1, dato_o, err_o);
    end
`else
    checks++;
    if (valid1 !== 1'b1 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL range_oob: valid1=%b err_o=%b, required 1 0", valid1, err_o);
    end
`endif
    tick();
    req1 = 1'b1; dir1 = 8'd2;
    tick();
    req1 = 1'b0;
    tick();
    checks++;
    if (valid1 !== 1'b1 || dato_o !== 8'd70 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL range_in: valid1=%b dato_o=%0d err_o=%b, required 1 70 0",
               valid1, dato_o, err_o);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    req0 = 1'b1; dir0 = 8'd5;
    tick();
    checks++;
    if (gnt0 !== 1'b1) begin
      errors++;
      $display("FAIL mid_gnt: gnt0=%b, required 1", gnt0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({gnt0, gnt1, valid0, valid1, ocupado} !== 5'b00000 ||
        {dato_o, err_o, dir_rom} !== 17'd0) begin
      errors++;
      $display("FAIL mid_abort: status=%b dato_o=%0d err_o=%b dir_rom=%0d, required 00000 0 0 0",
               {gnt0, gnt1, valid0, valid1, ocupado}, dato_o, err_o, dir_rom);
    end
    tick();
    checks++;
    if (gnt0 !== 1'b1 || dir_rom !== 8'd5) begin
      errors++;
      $display("FAIL mid_regnt: gnt0=%b dir_rom=%0d, required 1 5", gnt0, dir_rom);
    end
    req0 = 1'b0;
    tick();
    checks++;
    if (valid0 !== 1'b1 || dato_o !== 8'd40) begin
      errors++;
      $display("FAIL mid_rerun: valid0=%b dato_o=%0d, required 1 40", valid0, dato_o);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_req0();
    test_both_from_reset();
    test_back_to_back();
    test_range();
    test_reset_mid();
    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
